// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for NUM_DIG common-anode hex digits sharing one
// 7-segment decoder, with dead-time gaps between slots and optional leading-zero blanking.
module seg_scan_ctrl #(
    parameter int NUM_DIG = 4,
    parameter int AW      = 2,
    parameter int DIV     = 50000,
    parameter int GAP_CYC = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [3:0]         wr_data,
    input  logic               lzs_en,
    output logic [3:0]         dig_val,
    output logic [NUM_DIG-1:0] dig_sel,
    output logic               frame_tick
);

    localparam int MAXC = (DIV > GAP_CYC) ? DIV : GAP_CYC;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam logic [AW:0]   NUM_DIG_W = (AW + 1)'(NUM_DIG);
    localparam logic [AW-1:0] LAST_SLOT = AW'(NUM_DIG - 1);

    typedef enum logic {
        ST_GAP  = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [CW-1:0]       cnt_r, cnt_nxt_s;
    logic [AW-1:0]       slot_r, slot_nxt_s;
    logic                tick_r, tick_nxt_s;
    logic                lzs_r;
    logic [3:0]          regs_r [NUM_DIG];
    logic [NUM_DIG-1:0]  nz_from_s;
    logic                supp_s;
    logic [NUM_DIG-1:0]  dig_sel_s;
    logic [3:0]          dig_val_s;

    // Digit register file and sampled suppression enable; out-of-range writes are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIG; i++) begin
                regs_r[i] <= 4'h0;
            end
            lzs_r <= 1'b0;
        end else begin
            if (wr_en && ({1'b0, wr_addr} < NUM_DIG_W)) begin
                regs_r[wr_addr] <= wr_data;
            end
            lzs_r <= lzs_en;
        end
    end

    // Scan state register: FSM state, period counter, slot index and frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_GAP;
            cnt_r   <= CW'(GAP_CYC);
            slot_r  <= {AW{1'b0}};
            tick_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            slot_r  <= slot_nxt_s;
            tick_r  <= tick_nxt_s;
        end
    end

    // Next-state logic: the counter reloads on every state change, slot advances leaving SHOW.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r - CW'(1);
        slot_nxt_s  = slot_r;
        tick_nxt_s  = 1'b0;
        case (state_r)
            ST_GAP: begin
                if (cnt_r == CW'(1)) begin
                    state_nxt_s = ST_SHOW;
                    cnt_nxt_s   = CW'(DIV);
                end else begin
                    state_nxt_s = ST_GAP;
                end
            end
            ST_SHOW: begin
                if (cnt_r == CW'(1)) begin
                    state_nxt_s = ST_GAP;
                    cnt_nxt_s   = CW'(GAP_CYC);
                    if (slot_r == LAST_SLOT) begin
                        slot_nxt_s = {AW{1'b0}};
                        tick_nxt_s = 1'b1;
                    end else begin
                        slot_nxt_s = slot_r + AW'(1);
                    end
                end else begin
                    state_nxt_s = ST_SHOW;
                end
            end
            default: begin
                state_nxt_s = ST_GAP;
                cnt_nxt_s   = CW'(GAP_CYC);
                slot_nxt_s  = {AW{1'b0}};
            end
        endcase
    end

    // Output decode from registers only; nz_from_s[i] marks a nonzero digit at index i or above.
    always_comb begin
        nz_from_s = {NUM_DIG{1'b0}};
        for (int i = NUM_DIG - 1; i >= 0; i--) begin
            if (i == NUM_DIG - 1) begin
                nz_from_s[i] = (regs_r[i] != 4'h0);
            end else begin
                nz_from_s[i] = (regs_r[i] != 4'h0) | nz_from_s[i+1];
            end
        end
        supp_s    = lzs_r && (slot_r != {AW{1'b0}}) && !nz_from_s[slot_r];
        dig_val_s = regs_r[slot_r];
        dig_sel_s = {NUM_DIG{1'b1}};
        if ((state_r == ST_SHOW) && !supp_s) begin
            dig_sel_s[slot_r] = 1'b0;
        end else begin
            dig_sel_s = {NUM_DIG{1'b1}};
        end
    end

    assign dig_val    = dig_val_s;
    assign dig_sel    = dig_sel_s;
    assign frame_tick = tick_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NUM_DIG=4, DIV=4, GAP_CYC=2 (24-cycle frames).
module tb_seg_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic       lzs_en;
    logic [3:0] dig_val;
    logic [3:0] dig_sel;
    logic       frame_tick;

    int errors = 0;
    int checks = 0;

    logic [3:0] ev [4];
    logic [3:0] es [4];

    seg_scan_ctrl #(.NUM_DIG(4), .AW(2), .DIV(4), .GAP_CYC(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .lzs_en     (lzs_en),
        .dig_val    (dig_val),
        .dig_sel    (dig_sel),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [1:0] a, input logic [3:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    // Advance until frame_tick is seen, bounded to 40 cycles.
    task automatic wait_tick();
        bit seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            step();
            if (frame_tick === 1'b1) seen = 1'b1;
        end
        chk("wait_tick", {7'd0, seen}, 8'd1);
    endtask

    // Check one 24-cycle frame starting at its first GAP cycle; ends at the next frame start.
    task automatic run_frame(input string tag, input logic tick0);
        for (int k = 0; k < 24; k++) begin
            int s = k / 6;
            int p = k % 6;
            chk({tag, "_sel"}, {4'd0, dig_sel}, {4'd0, (p < 2) ? 4'hF : es[s]});
            chk({tag, "_val"}, {4'd0, dig_val}, {4'd0, ev[s]});
            chk({tag, "_tick"}, {7'd0, frame_tick}, {7'd0, (k == 0) ? tick0 : 1'b0});
            step();
        end
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 4'h0; lzs_en = 1'b0;
        repeat (3) step();
        chk("rst_sel", {4'd0, dig_sel}, 8'h0F);
        chk("rst_val", {4'd0, dig_val}, 8'h00);
        chk("rst_tick", {7'd0, frame_tick}, 8'h00);

        // First slot-0 SHOW after exactly two GAP cycles.
        rst_n = 1'b1;
        chk("gap0_sel", {4'd0, dig_sel}, 8'h0F);
        step();
        chk("gap1_sel", {4'd0, dig_sel}, 8'h0F);
        step();
        chk("show0_sel", {4'd0, dig_sel}, 8'h0E);
        chk("show0_val", {4'd0, dig_val}, 8'h00);

        // Basic scan with regs {3:A,2:0,1:5,0:7}, then a free-run frame.
        write(2'd0, 4'h7);
        write(2'd1, 4'h5);
        write(2'd2, 4'h0);
        write(2'd3, 4'hA);
        wait_tick();
        ev[0] = 4'h7; ev[1] = 4'h5; ev[2] = 4'h0; ev[3] = 4'hA;
        es[0] = 4'hE; es[1] = 4'hD; es[2] = 4'hB; es[3] = 4'h7;
        run_frame("scan", 1'b1);
        run_frame("free", 1'b1);

        // Leading-zero suppression with regs {0,0,1,0}.
        lzs_en = 1'b1;
        write(2'd0, 4'h0);
        write(2'd1, 4'h1);
        write(2'd2, 4'h0);
        write(2'd3, 4'h0);
        wait_tick();
        ev[0] = 4'h0; ev[1] = 4'h1; ev[2] = 4'h0; ev[3] = 4'h0;
        es[0] = 4'hE; es[1] = 4'hD; es[2] = 4'hF; es[3] = 4'hF;
        run_frame("lzs", 1'b1);

        // All zero: only slot 0 lights.
        write(2'd1, 4'h0);
        wait_tick();
        ev[1] = 4'h0;
        es[1] = 4'hF;
        run_frame("lzs0", 1'b1);

        // Mid-SHOW write to slot 1; now at frame cycle k=0.
        lzs_en = 1'b0;
        repeat (8) step();
        chk("mid_sel8", {4'd0, dig_sel}, 8'h0D);
        chk("mid_val8", {4'd0, dig_val}, 8'h00);
        write(2'd1, 4'hC);
        chk("mid_sel9", {4'd0, dig_sel}, 8'h0D);
        chk("mid_val9", {4'd0, dig_val}, 8'h0C);
        step();
        chk("mid_sel10", {4'd0, dig_sel}, 8'h0D);
        step();
        chk("mid_sel11", {4'd0, dig_sel}, 8'h0D);
        step();
        chk("mid_sel12", {4'd0, dig_sel}, 8'h0F);
        repeat (5) step();
        // k=17: last SHOW cycle of slot 2; write slot 3 on the advancing edge.
        chk("adv_sel17", {4'd0, dig_sel}, 8'h0B);
        write(2'd3, 4'h9);
        chk("adv_val18", {4'd0, dig_val}, 8'h09);
        chk("adv_sel18", {4'd0, dig_sel}, 8'h0F);
        repeat (2) step();
        chk("adv_sel20", {4'd0, dig_sel}, 8'h07);
        chk("adv_val20", {4'd0, dig_val}, 8'h09);
        write(2'd2, 4'h3);
        // Now k=21; advance to slot 2 SHOW of next frame (k=24+15).
        repeat (18) step();
        chk("pre_rst_sel", {4'd0, dig_sel}, 8'h0B);
        chk("pre_rst_val", {4'd0, dig_val}, 8'h03);

        // Asynchronous reset mid-SHOW.
        rst_n = 1'b0;
        #1;
        chk("arst_sel", {4'd0, dig_sel}, 8'h0F);
        chk("arst_val", {4'd0, dig_val}, 8'h00);
        chk("arst_tick", {7'd0, frame_tick}, 8'h00);
        step();
        rst_n = 1'b1;
        ev[0] = 4'h0; ev[1] = 4'h0; ev[2] = 4'h0; ev[3] = 4'h0;
        es[0] = 4'hE; es[1] = 4'hD; es[2] = 4'hB; es[3] = 4'h7;
        run_frame("post_rst", 1'b0);
        chk("post_rst_wrap", {7'd0, frame_tick}, 8'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
